// File: rtl/lpif_asym2_tx_pack_ctrl.sv
// Packs full-rate 77-bit LPIF beats in pairs into 154-bit txfifo words.
// Handles back-pressure, timeout and requested flushes of a lone beat, and gen1 single-beat mode.
module lpif_asym2_tx_pack_ctrl #(
    parameter int FLUSH_TO = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk_wr,
    input  logic              rst_wr_n,
    input  logic              m_gen2_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [76:0]       in_beat,
    input  logic              flush_req,
    input  logic              txfifo_full,
    output logic              txfifo_push,
    output logic [153:0]      txfifo_data,
    output logic              held,
    output logic [CNT_W-1:0]  pad_cnt
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_HALF = 1'b1} state_t;

    localparam logic [7:0] TO_MAX = 8'(FLUSH_TO);

    state_t             r_state;
    logic [76:0]        r_held_beat;
    logic [7:0]         r_to_cnt;
    logic               r_push;
    logic [153:0]       r_data;
    logic               r_held;
    logic [CNT_W-1:0]   r_pad_cnt;

    logic               w_mode_flush;
    logic               w_ready;
    logic               w_accept;
    logic               w_flush_trig;

    // Filler beat: only the link state survives, everything else is zero/invalid.
    function automatic logic [76:0] make_pad(input logic [76:0] src);
        logic [76:0] pad;
        pad      = '0;
        pad[3:0] = src[3:0];
        return pad;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    assign w_mode_flush = (r_state == ST_HALF) && !m_gen2_mode;
    assign w_flush_trig = (r_to_cnt == TO_MAX) || flush_req || !m_gen2_mode;

    always_comb begin
        w_ready = 1'b0;
        if (w_mode_flush)
            w_ready = 1'b0;
        else if (m_gen2_mode)
            w_ready = (r_state == ST_EMPTY) ? 1'b1 : !txfifo_full;
        else
            w_ready = (r_state == ST_EMPTY) && !txfifo_full;
    end

    assign w_accept = in_valid && w_ready;

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            r_state   <= ST_EMPTY;
            r_to_cnt  <= '0;
            r_push    <= 1'b0;
            r_data    <= '0;
            r_held    <= 1'b0;
            r_pad_cnt <= '0;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        if (m_gen2_mode) begin
                            r_held_beat <= in_beat;
                            r_to_cnt    <= '0;
                            r_state     <= ST_HALF;
                            r_held      <= 1'b1;
                        end else begin
                            r_push    <= 1'b1;
                            r_data    <= {make_pad(in_beat), in_beat};
                            r_pad_cnt <= sat_inc(r_pad_cnt);
                        end
                    end
                end
                ST_HALF: begin
                    // A beat arriving alongside a flush trigger completes the pair instead.
                    if (w_accept) begin
                        r_push  <= 1'b1;
                        r_data  <= {in_beat, r_held_beat};
                        r_state <= ST_EMPTY;
                        r_held  <= 1'b0;
                    end else if (w_flush_trig && !txfifo_full) begin
                        r_push    <= 1'b1;
                        r_data    <= {make_pad(r_held_beat), r_held_beat};
                        r_pad_cnt <= sat_inc(r_pad_cnt);
                        r_state   <= ST_EMPTY;
                        r_held    <= 1'b0;
                    end else if (r_to_cnt != TO_MAX) begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign in_ready    = w_ready;
    assign txfifo_push = r_push;
    assign txfifo_data = r_data;
    assign held        = r_held;
    assign pad_cnt     = r_pad_cnt;

endmodule

// File: tb/tb_lpif_asym2_tx_pack_ctrl.sv
// Directed bench for lpif_asym2_tx_pack_ctrl: pairing, timeout, back-pressure, gen1, mode change, reset.
module tb_lpif_asym2_tx_pack_ctrl;

    localparam int FLUSH_TO = 8;
    localparam int CNT_W    = 16;

    logic              clk_wr = 1'b0;
    logic              rst_wr_n;
    logic              m_gen2_mode;
    logic              in_valid;
    logic              in_ready;
    logic [76:0]       in_beat;
    logic              flush_req;
    logic              txfifo_full;
    logic              txfifo_push;
    logic [153:0]      txfifo_data;
    logic              held;
    logic [CNT_W-1:0]  pad_cnt;

    int total = 0;
    int bad   = 0;

    lpif_asym2_tx_pack_ctrl #(.FLUSH_TO(FLUSH_TO), .CNT_W(CNT_W)) dut (
        .clk_wr      (clk_wr),
        .rst_wr_n    (rst_wr_n),
        .m_gen2_mode (m_gen2_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_beat     (in_beat),
        .flush_req   (flush_req),
        .txfifo_full (txfifo_full),
        .txfifo_push (txfifo_push),
        .txfifo_data (txfifo_data),
        .held        (held),
        .pad_cnt     (pad_cnt)
    );

    always #5 clk_wr = ~clk_wr;

    // {valid, crc_valid, crc, dvalid, data, protid, state}
    function automatic logic [76:0] mk(input logic v, input logic [63:0] d, input logic [3:0] st);
        return {v, 1'b0, 4'h0, 1'b1, d, 2'b01, st};
    endfunction

    function automatic logic [76:0] pad_of(input logic [76:0] b);
        return {73'd0, b[3:0]};
    endfunction

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic test_reset();
        rst_wr_n = 1'b0; m_gen2_mode = 1'b1; in_valid = 1'b0; in_beat = '0;
        flush_req = 1'b0; txfifo_full = 1'b0;
        step(); step();
        rst_wr_n = 1'b1;
        #1;
        total++; if (txfifo_push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b want=0", txfifo_push); end
        total++; if (txfifo_data !== 154'd0) begin bad++; $display("FAIL reset_data got=%h want=0", txfifo_data); end
        total++; if (held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b want=0", held); end
        total++; if (pad_cnt !== 16'd0) begin bad++; $display("FAIL reset_padcnt got=%0d want=0", pad_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_pair();
        logic [76:0] a, b;
        a = mk(1'b1, 64'h1111, 4'h3);
        b = mk(1'b1, 64'h2222, 4'h3);
        m_gen2_mode = 1'b1;
        in_valid = 1'b1; in_beat = a;
        step();
        total++; if (held !== 1'b1 || txfifo_push !== 1'b0) begin bad++; $display("FAIL pair_after_a held=%b push=%b want held=1 push=0", held, txfifo_push); end
        in_beat = b;
        step();
        in_valid = 1'b0;
        total++; if (txfifo_push !== 1'b1) begin bad++; $display("FAIL pair_push got=%b want=1", txfifo_push); end
        total++; if (txfifo_data[6+:64] !== 64'h1111 || txfifo_data[83+:64] !== 64'h2222) begin bad++; $display("FAIL pair_data lo=%h hi=%h want 1111/2222", txfifo_data[6+:64], txfifo_data[83+:64]); end
        total++; if (txfifo_data !== {b, a}) begin bad++; $display("FAIL pair_word got=%h want=%h", txfifo_data, {b, a}); end
        total++; if (pad_cnt !== 16'd0 || held !== 1'b0) begin bad++; $display("FAIL pair_state padcnt=%0d held=%b want 0/0", pad_cnt, held); end
        step();
        total++; if (txfifo_push !== 1'b0 || txfifo_data !== {b, a}) begin bad++; $display("FAIL pair_hold push=%b data=%h want push=0 data unchanged", txfifo_push, txfifo_data); end
    endtask

    task automatic test_timeout();
        logic [76:0] a;
        int n;
        a = mk(1'b1, 64'hABCD, 4'h5);
        in_valid = 1'b1; in_beat = a;
        step();
        in_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (txfifo_push === 1'b1) break;
        end
        total++; if (n !== FLUSH_TO + 1) begin bad++; $display("FAIL timeout_latency got=%0d want=%0d", n, FLUSH_TO + 1); end
        total++; if (txfifo_data !== {pad_of(a), a}) begin bad++; $display("FAIL timeout_word got=%h want=%h", txfifo_data, {pad_of(a), a}); end
        total++; if (txfifo_data[153] !== 1'b0 || txfifo_data[77+:4] !== 4'h5) begin bad++; $display("FAIL timeout_pad v=%b st=%h want 0/5", txfifo_data[153], txfifo_data[77+:4]); end
        total++; if (pad_cnt !== 16'd1 || held !== 1'b0) begin bad++; $display("FAIL timeout_state padcnt=%0d held=%b want 1/0", pad_cnt, held); end
    endtask

    task automatic test_full_hold();
        logic [76:0] a, b;
        int pushes;
        a = mk(1'b1, 64'h3333, 4'h6);
        b = mk(1'b1, 64'h4444, 4'h6);
        in_valid = 1'b1; in_beat = a;
        step();
        txfifo_full = 1'b1; in_beat = b;
        pushes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (txfifo_push === 1'b1) pushes++;
        end
        total++; if (pushes !== 0) begin bad++; $display("FAIL full_no_push got=%0d want=0", pushes); end
        total++; if (in_ready !== 1'b0 || held !== 1'b1) begin bad++; $display("FAIL full_ready ready=%b held=%b want 0/1", in_ready, held); end
        txfifo_full = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_release_ready got=%b want=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (txfifo_push !== 1'b1 || txfifo_data !== {b, a}) begin bad++; $display("FAIL full_pair push=%b data=%h want 1/%h", txfifo_push, txfifo_data, {b, a}); end
        total++; if (pad_cnt !== 16'd1) begin bad++; $display("FAIL full_padcnt got=%0d want=1", pad_cnt); end
        step();
    endtask

    task automatic test_flush_req();
        logic [76:0] a;
        a = mk(1'b1, 64'h5555, 4'h2);
        flush_req = 1'b1;
        step();
        total++; if (txfifo_push !== 1'b0 || held !== 1'b0) begin bad++; $display("FAIL flush_empty push=%b held=%b want 0/0", txfifo_push, held); end
        flush_req = 1'b0;
        in_valid = 1'b1; in_beat = a;
        step();
        in_valid = 1'b0; flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        total++; if (txfifo_push !== 1'b1 || txfifo_data !== {pad_of(a), a}) begin bad++; $display("FAIL flush_req push=%b data=%h want 1/%h", txfifo_push, txfifo_data, {pad_of(a), a}); end
        total++; if (pad_cnt !== 16'd2) begin bad++; $display("FAIL flush_padcnt got=%0d want=2", pad_cnt); end
        step();
    endtask

    task automatic test_gen1();
        logic [76:0] beats [3];
        beats[0] = mk(1'b1, 64'hA0A0, 4'h1);
        beats[1] = mk(1'b1, 64'hB0B0, 4'h7);
        beats[2] = mk(1'b1, 64'hC0C0, 4'h9);
        m_gen2_mode = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_beat = beats[i];
            step();
            total++; if (txfifo_push !== 1'b1 || txfifo_data !== {pad_of(beats[i]), beats[i]}) begin bad++; $display("FAIL gen1_beat%0d push=%b data=%h want 1/%h", i, txfifo_push, txfifo_data, {pad_of(beats[i]), beats[i]}); end
        end
        in_valid = 1'b0;
        total++; if (pad_cnt !== 16'd5) begin bad++; $display("FAIL gen1_padcnt got=%0d want=5", pad_cnt); end
        step();
    endtask

    task automatic test_mode_change();
        logic [76:0] a, b;
        a = mk(1'b1, 64'hD1D1, 4'h4);
        b = mk(1'b1, 64'hE2E2, 4'h8);
        m_gen2_mode = 1'b1;
        in_valid = 1'b1; in_beat = a;
        step();
        m_gen2_mode = 1'b0; in_beat = b;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mode_ready got=%b want=0", in_ready); end
        step();
        total++; if (txfifo_push !== 1'b1 || txfifo_data !== {pad_of(a), a}) begin bad++; $display("FAIL mode_first push=%b data=%h want 1/%h", txfifo_push, txfifo_data, {pad_of(a), a}); end
        step();
        in_valid = 1'b0;
        total++; if (txfifo_push !== 1'b1 || txfifo_data !== {pad_of(b), b}) begin bad++; $display("FAIL mode_second push=%b data=%h want 1/%h", txfifo_push, txfifo_data, {pad_of(b), b}); end
        step();
        total++; if (txfifo_push !== 1'b0 || pad_cnt !== 16'd7) begin bad++; $display("FAIL mode_end push=%b padcnt=%0d want 0/7", txfifo_push, pad_cnt); end
    endtask

    task automatic test_reset_half();
        logic [76:0] a, c, d;
        a = mk(1'b1, 64'hF0F0, 4'hA);
        c = mk(1'b1, 64'h0C0C, 4'hB);
        d = mk(1'b0, 64'h0D0D, 4'hB);
        m_gen2_mode = 1'b1;
        in_valid = 1'b1; in_beat = a;
        step();
        in_valid = 1'b0; rst_wr_n = 1'b0;
        step();
        rst_wr_n = 1'b1;
        total++; if (held !== 1'b0 || txfifo_push !== 1'b0 || pad_cnt !== 16'd0) begin bad++; $display("FAIL rst_half held=%b push=%b padcnt=%0d want 0/0/0", held, txfifo_push, pad_cnt); end
        in_valid = 1'b1; in_beat = c;
        step();
        in_beat = d;
        step();
        in_valid = 1'b0;
        total++; if (txfifo_push !== 1'b1 || txfifo_data !== {d, c}) begin bad++; $display("FAIL rst_pair push=%b data=%h want 1/%h", txfifo_push, txfifo_data, {d, c}); end
        total++; if (pad_cnt !== 16'd0) begin bad++; $display("FAIL rst_padcnt got=%0d want=0", pad_cnt); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_timeout();
        test_full_hold();
        test_flush_req();
        test_gen1();
        test_mode_change();
        test_reset_half();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
